hamming_decoder_pipe: RTL

- Pipelined Hamming(7,4) decoder with single-error correction. It is the receive-side counterpart of the team's combinational Hamming(7,4) encoder.
- Accepts 7-bit codewords over a valid/ready stream, computes the syndrome, corrects any single-bit error and emits the 4-bit data with status flags.
- Keeps a saturating count of corrected words for link-quality monitoring.
- Sits between the channel/error-injection logic and the data consumer.

---
 rtl/hamming_decoder_pipe.sv | 112 +++++++++++
 1 files changed

// File: rtl/hamming_decoder_pipe.sv
// Two-stage pipelined Hamming(7,4) decoder with single-error correction and a
// saturating count of corrected words delivered to the consumer.
module hamming_decoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic [2:0]       syndrome,
    output logic             err_corrected,
    output logic             err_in_parity,
    input  logic             clr_count,
    output logic [CNT_W-1:0] corr_count
);

    logic             s2_en;
    logic             in_fire;
    logic             out_fire;
    logic [2:0]       syn_c;
    logic [3:0]       data_c;

    logic [6:0]       code_p1;
    logic             vld_p1;

    logic             vld_p2;
    logic [3:0]       data_p2;
    logic [2:0]       syn_p2;
    logic             corr_p2;
    logic             par_p2;
    logic [CNT_W-1:0] cnt_p2;

    function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
        return {c[3] ^ c[2] ^ c[1] ^ c[0],
                c[5] ^ c[4] ^ c[1] ^ c[0],
                c[6] ^ c[4] ^ c[2] ^ c[0]};
    endfunction

    // A data bit is inverted only when the syndrome names its Hamming position.
    function automatic logic [3:0] correct_data(input logic [6:0] c, input logic [2:0] s);
        return {c[0] ^ (s == 3'd7),
                c[1] ^ (s == 3'd6),
                c[2] ^ (s == 3'd5),
                c[4] ^ (s == 3'd3)};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign s2_en    = !vld_p2 || out_ready;
    assign in_ready = rst_n && (!vld_p1 || s2_en);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_p2 && out_ready;

    // Stage 1: capture the raw codeword
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            code_p1 <= 7'd0;
        end else if (in_fire) begin
            vld_p1  <= 1'b1;
            code_p1 <= code_in;
        end else if (s2_en) begin
            vld_p1  <= 1'b0;
        end
    end

    assign syn_c  = calc_syndrome(code_p1);
    assign data_c = correct_data(code_p1, syn_c);

    // Stage 2: syndrome, corrected data and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= 4'd0;
            syn_p2  <= 3'd0;
            corr_p2 <= 1'b0;
            par_p2  <= 1'b0;
        end else if (s2_en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= data_c;
                syn_p2  <= syn_c;
                corr_p2 <= (syn_c != 3'd0);
                par_p2  <= (syn_c == 3'd1) || (syn_c == 3'd2) || (syn_c == 3'd4);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p2 <= '0;
        end else if (clr_count) begin
            cnt_p2 <= '0;
        end else if (out_fire && corr_p2) begin
            cnt_p2 <= sat_inc(cnt_p2);
        end
    end

    assign out_valid     = vld_p2;
    assign data_out      = data_p2;
    assign syndrome      = syn_p2;
    assign err_corrected = corr_p2;
    assign err_in_parity = par_p2;
    assign corr_count    = cnt_p2;

endmodule
